// File: rtl/i2s_audio_tx_pkg.sv
`default_nettype none
// ============================================================================
// i2s_audio_tx_pkg : shared audio/I2S constants, FSM state type, WS decode
// Revision: 1.0
// ============================================================================
package i2s_audio_tx_pkg;

  localparam int AUDIO_SAMPLE_W          = 16;
  localparam int I2S_FRAME_SLOTS         = 32;
  localparam int I2S_FRAME_W             = 2 * AUDIO_SAMPLE_W;
  localparam int I2S_SLOT_W              = 5;
  localparam int I2S_WS_RIGHT_FIRST_SLOT = 15;
  localparam int I2S_WS_RIGHT_LAST_SLOT  = 30;

  typedef enum logic [0:0] {
    IDLE_SYNC = 1'b0,
    RUN       = 1'b1
  } i2s_state_e;

  // WS leads data by one slot, so the right-channel window is shifted down by one.
  function automatic logic ws_for_slot(input logic [I2S_SLOT_W-1:0] slot);
    return (int'(slot) >= I2S_WS_RIGHT_FIRST_SLOT) && (int'(slot) <= I2S_WS_RIGHT_LAST_SLOT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_bck_gen.sv
`default_nettype none
// ============================================================================
// i2s_bck_gen : BCK prescaler/toggle with one-clk rise and fall event strobes
// Revision: 1.0
// ============================================================================
module i2s_bck_gen #(
  parameter int BCK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic o_bck,
  output logic o_fall_evt,
  output logic o_rise_evt
);

  localparam logic [7:0] c_div_last = 8'(BCK_DIV - 1);

  logic [7:0] r_div_cnt;
  logic       r_bck;
  logic       w_tc;

  assign w_tc = (r_div_cnt == c_div_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_bck     <= 1'b0;
    end else if (w_tc) begin
      r_div_cnt <= '0;
      r_bck     <= ~r_bck;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

  // Events describe the edge that BCK is about to make at the end of this cycle.
  assign o_fall_evt = w_tc & r_bck;
  assign o_rise_evt = w_tc & ~r_bck;
  assign o_bck      = r_bck;

endmodule
`default_nettype wire

// File: rtl/i2s_audio_tx.sv
`default_nettype none
// ============================================================================
// i2s_audio_tx : stereo 16-bit parallel to Philips I2S serializer
// Revision: 1.0
// ============================================================================
module i2s_audio_tx
  import i2s_audio_tx_pkg::*;
#(
  parameter int BCK_DIV = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AUDIO_SAMPLE_W-1:0] left,
  input  logic [AUDIO_SAMPLE_W-1:0] right,
  input  logic                      mute,
  output logic                      frame_strobe,
  output logic                      i2s_bck,
  output logic                      i2s_ws,
  output logic                      i2s_data
);

  localparam logic [I2S_SLOT_W-1:0] c_last_slot = I2S_SLOT_W'(I2S_FRAME_SLOTS - 1);

  logic                   w_fall_evt;
  logic                   w_rise_evt_unused;
  i2s_state_e             r_state;
  i2s_state_e             w_state_next;
  logic                   w_capture;
  logic                   w_shift;
  logic [I2S_SLOT_W-1:0]  r_slot;
  logic [I2S_SLOT_W-1:0]  w_slot_next;
  logic [I2S_FRAME_W-1:0] r_shifter;
  logic                   r_ws;

  i2s_bck_gen #(
    .BCK_DIV (BCK_DIV)
  ) u_bck_gen (
    .clk        (clk),
    .reset      (reset),
    .o_bck      (i2s_bck),
    .o_fall_evt (w_fall_evt),
    .o_rise_evt (w_rise_evt_unused)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE_SYNC: if (w_fall_evt) w_state_next = RUN;
      RUN:       w_state_next = RUN;
      default:   w_state_next = IDLE_SYNC;
    endcase
  end

  // The very first falling edge after reset always starts a frame at slot 0.
  always_comb begin
    w_capture = 1'b0;
    w_shift   = 1'b0;
    case (r_state)
      IDLE_SYNC: begin
        w_capture = w_fall_evt;
      end
      RUN: begin
        w_capture = w_fall_evt && (r_slot == c_last_slot);
        w_shift   = w_fall_evt && (r_slot != c_last_slot);
      end
      default: begin
        w_capture = 1'b0;
        w_shift   = 1'b0;
      end
    endcase
  end

  assign w_slot_next = r_slot + I2S_SLOT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot    <= c_last_slot;
      r_shifter <= '0;
      r_ws      <= 1'b0;
    end else begin
      if (w_fall_evt) begin
        r_slot <= w_slot_next;
        r_ws   <= ws_for_slot(w_slot_next);
      end
      if (w_capture) begin
        r_shifter <= mute ? '0 : {left, right};
      end else if (w_shift) begin
        r_shifter <= {r_shifter[I2S_FRAME_W-2:0], 1'b0};
      end
    end
  end

  assign frame_strobe = w_capture;
  assign i2s_ws       = r_ws;
  assign i2s_data     = r_shifter[I2S_FRAME_W-1];

endmodule
`default_nettype wire
